// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the regfile_sb register file.
package regfile_sb_pkg;

  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  localparam int AW_D   = $clog2(NREG_D);
  localparam int ADDR_MAX_W = 16;

  typedef logic [AW_D-1:0] reg_addr_t;

  // Callers zero-extend their address to ADDR_MAX_W so the same helper serves any NREG.
  function automatic logic zero_reg(input logic [ADDR_MAX_W-1:0] addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_sb_busy.sv
// Per-register busy scoreboard: issue sets, writeback clears, flush and reset clear all.
module regfile_sb_busy
  import regfile_sb_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic            flush,
  output logic [NREG-1:0] busy,
  output logic            all_idle
);

  logic [NREG-1:1] busy_q;
  logic [NREG-1:1] busy_d;

  // Set has priority over clear: a new producer owns the register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (set_en && set_addr == AW'(i))
        busy_d[i] = 1'b1;
      else if (clr_en && clr_addr == AW'(i))
        busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy     = {busy_q, 1'b0};
  assign all_idle = ~|busy_q;

endmodule

// File: rtl/regfile_sb.sv
// NRD-read/1-write register file with busy scoreboard; REGFILE_SB_BYPASS_EN adds wd->rd bypass.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic                all_idle
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic            wr_en;
  logic            set_en;

  assign wr_en  = we && !zero_reg(ADDR_MAX_W'(wa));
  assign set_en = iss_valid && !zero_reg(ADDR_MAX_W'(iss_rd));

  // Register 0 is never written, so after reset it reads as zero forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[wa] <= wd;
    end
  end

  regfile_sb_busy #(
    .NREG (NREG),
    .AW   (AW)
  ) u_busy (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_addr (iss_rd),
    .clr_en   (wr_en),
    .clr_addr (wa),
    .flush    (flush),
    .busy     (busy),
    .all_idle (all_idle)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra_k;
    assign ra_k = ra[k*AW +: AW];

    always_comb begin
      rd[k*XLEN +: XLEN] = '0;
      rbusy[k]           = 1'b0;
      if (!zero_reg(ADDR_MAX_W'(ra_k))) begin
`ifdef REGFILE_SB_BYPASS_EN
        if (wr_en && ra_k == wa) begin
          rd[k*XLEN +: XLEN] = wd;
          rbusy[k]           = set_en && !flush && iss_rd == wa;
        end else begin
          rd[k*XLEN +: XLEN] = mem[ra_k];
          rbusy[k]           = busy[ra_k];
        end
`else
        rd[k*XLEN +: XLEN] = mem[ra_k];
        rbusy[k]           = busy[ra_k];
`endif
      end
    end
  end

endmodule
